xc_malu_muldivrem_seq: RTL and testbench



---
 rtl/xc_malu_muldivrem_seq.sv | 157 +++++++++++++++
 tb/tb_xc_malu_muldivrem_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_muldivrem_seq.sv
// Iterative multiply/divide/remainder unit: shift-add multiply, restoring divide, UNROLL bits/cycle.
// Define XC_MALU_MULDIVREM_EARLY_OUT_EN to skip iteration for divide-by-zero and zero multiplies.
module xc_malu_muldivrem_seq #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int unsigned Iters = XLEN / UNROLL;
    localparam int unsigned CntW  = $clog2(Iters + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div, a_signed, b_signed, a_neg, b_neg, b_zero, early;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] load_acc, step_acc, prod;
    logic [XLEN-1:0]   quo, rem, sel;
    logic [XLEN:0]     part, diff, sum;

    // Request decode: operand magnitudes and the sign to apply at the end.
    always_comb begin
        is_div   = op[2];
        a_signed = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        b_signed = is_div ? ~op[0] : (op[1:0] == 2'b01);
        a_neg    = a_signed & rs1[XLEN-1];
        b_neg    = b_signed & rs2[XLEN-1];
        mag_a    = a_neg ? -rs1 : rs1;
        mag_b    = b_neg ? -rs2 : rs2;
        b_zero   = (rs2 == '0);
        neg_d    = is_div ? (op[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero)) : (a_neg ^ b_neg);
`ifdef XC_MALU_MULDIVREM_EARLY_OUT_EN
        early    = is_div ? b_zero : (b_zero || rs1 == '0);
`else
        early    = 1'b0;
`endif
        // Early-out loads the finished accumulator: all-ones quotient / zero product.
        if (early) load_acc = is_div ? {mag_a, {XLEN{1'b1}}} : '0;
        else       load_acc = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
    end

    // UNROLL iterations per cycle; acc is {partial remainder | product high, dividend | multiplier}.
    always_comb begin
        step_acc = acc_q;
        part     = '0;
        diff     = '0;
        sum      = '0;
        for (int i = 0; i < int'(UNROLL); i++) begin
            if (op_q[2]) begin
                part = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
                diff = part - {1'b0, opb_q};
                if (diff[XLEN]) step_acc = {part[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
                else            step_acc = {diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
            end else begin
                sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, opa_q} : '0);
                step_acc = {sum, step_acc[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 sel = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel = quo;
            default:                sel = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d    = op;
                        opa_d   = mag_a;
                        opb_d   = mag_b;
                        acc_d   = load_acc;
                        cnt_d   = CntW'(Iters);
                        state_d = early ? StFix : StCalc;
                    end
                end
                StCalc: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) state_d = StFix;
                end
                StFix: begin
                    result_d = sel;
                    state_d  = StDone;
                end
                default: begin
                    if (out_ready) state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StIdle;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= (state_q == StIdle) ? neg_d : neg_q;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;

endmodule

// File: tb/tb_xc_malu_muldivrem_seq.sv
// Bench for xc_malu_muldivrem_seq: UNROLL=1 and UNROLL=4 instances against an arithmetic model.
`timescale 1ns/1ps
module tb_xc_malu_muldivrem_seq;
    localparam int unsigned XLEN = 32;

    logic            clock = 1'b0;
    logic            resetn;
    logic            flush     [2];
    logic            in_valid  [2];
    logic            in_ready  [2];
    logic [2:0]      op        [2];
    logic [XLEN-1:0] rs1       [2];
    logic [XLEN-1:0] rs2       [2];
    logic            out_valid [2];
    logic            out_ready [2];
    logic [XLEN-1:0] result    [2];
    logic            busy      [2];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    xc_malu_muldivrem_seq #(.XLEN(32), .UNROLL(1)) u_mdr1 (
        .clock(clock), .resetn(resetn), .flush(flush[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .op(op[0]), .rs1(rs1[0]), .rs2(rs2[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0])
    );

    xc_malu_muldivrem_seq #(.XLEN(32), .UNROLL(4)) u_mdr4 (
        .clock(clock), .resetn(resetn), .flush(flush[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .op(op[1]), .rs1(rs1[1]), .rs2(rs2[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Plain arithmetic reference for every opcode.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (o)
            3'd0: p = ua * ub;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = ua * ub;
            default: p = '0;
        endcase
        case (o)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5:    begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input int i, input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef XC_MALU_MULDIVREM_EARLY_OUT_EN
        if (o[2] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
        return 32 / ((i == 0) ? 1 : 4) + 1;
    endfunction

    // Transaction-level model: 0 idle, 1 computing, 2 result held.
    int              m_phase [2];
    int              m_cnt   [2];
    logic [XLEN-1:0] m_exp   [2];
    logic [XLEN-1:0] m_res   [2];
    logic            m_init = 1'b0;

    always @(posedge clock) begin
        if (!resetn) m_init <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                m_phase[i] <= 0;
                m_res[i]   <= '0;
            end else if (flush[i]) begin
                m_phase[i] <= 0;
            end else begin
                case (m_phase[i])
                    0: if (in_valid[i]) begin
                        m_exp[i]   <= ref_result(op[i], rs1[i], rs2[i]);
                        m_cnt[i]   <= ref_lat(i, op[i], rs1[i], rs2[i]);
                        m_phase[i] <= 1;
                    end
                    1: if (m_cnt[i] == 1) begin
                        m_phase[i] <= 2;
                        m_res[i]   <= m_exp[i];
                    end else begin
                        m_cnt[i] <= m_cnt[i] - 1;
                    end
                    default: if (out_ready[i]) m_phase[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (m_init) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d_in_ready", i), 64'(in_ready[i]), 64'(m_phase[i] == 0));
                chk($sformatf("u%0d_out_valid", i), 64'(out_valid[i]), 64'(m_phase[i] == 2));
                chk($sformatf("u%0d_busy", i), 64'(busy[i]), 64'(m_phase[i] != 0));
                chk($sformatf("u%0d_result", i), 64'(result[i]), 64'(m_res[i]));
            end
        end
    end

    task automatic do_op(input int i, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                         input int hold);
        int n;
        n = 0;
        while (!in_ready[i] && n < 100) begin @(negedge clock); n++; end
        in_valid[i] = 1'b1;
        op[i]       = o;
        rs1[i]      = a;
        rs2[i]      = b;
        @(negedge clock);
        in_valid[i] = 1'b0;
        op[i]       = 3'($urandom);
        rs1[i]      = $urandom;
        rs2[i]      = $urandom;
        n = 0;
        while (!out_valid[i] && n < 200) begin @(negedge clock); n++; end
        chk($sformatf("u%0d_op%0d_latency", i, o), 64'(n), 64'(exp_lat));
        chk($sformatf("u%0d_op%0d_value", i, o), 64'(result[i]), 64'(exp_res));
        if (!out_valid[i]) begin
            flush[i] = 1'b1;
            @(negedge clock);
            flush[i] = 1'b0;
            return;
        end
        for (int k = 0; k < hold; k++) begin
            rs1[i] = $urandom;
            rs2[i] = $urandom;
            @(negedge clock);
            chk($sformatf("u%0d_hold_value", i), 64'(result[i]), 64'(exp_res));
            chk($sformatf("u%0d_hold_ready", i), 64'(in_ready[i]), 64'(0));
        end
        // A request offered in the handshake cycle must be ignored.
        out_ready[i] = 1'b1;
        in_valid[i]  = 1'b1;
        @(negedge clock);
        out_ready[i] = 1'b0;
        in_valid[i]  = 1'b0;
        chk($sformatf("u%0d_after_ready", i), 64'(in_ready[i]), 64'(1));
        chk($sformatf("u%0d_after_valid", i), 64'(out_valid[i]), 64'(0));
    endtask

    function automatic logic [31:0] pick(input int unsigned r);
        case (r % 8)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    int full_lat;
    int zero_lat;

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            flush[i] = 1'b0; in_valid[i] = 1'b0; op[i] = '0;
            rs1[i] = '0; rs2[i] = '0; out_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_rst_in_ready", i), 64'(in_ready[i]), 64'(1));
            chk($sformatf("u%0d_rst_out_valid", i), 64'(out_valid[i]), 64'(0));
            chk($sformatf("u%0d_rst_result", i), 64'(result[i]), 64'(0));
            chk($sformatf("u%0d_rst_busy", i), 64'(busy[i]), 64'(0));
        end

        for (int i = 0; i < 2; i++) begin
            full_lat = (i == 0) ? 33 : 9;
`ifdef XC_MALU_MULDIVREM_EARLY_OUT_EN
            zero_lat = 1;
`else
            zero_lat = full_lat;
`endif
            do_op(i, 3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, full_lat, 0);
            do_op(i, 3'd3, 32'hFFFF_FFFF, 32'h2, 32'h1, full_lat, 0);
            do_op(i, 3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, full_lat, 10);
            do_op(i, 3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, full_lat, 0);
            do_op(i, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, full_lat, 0);
            do_op(i, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, full_lat, 0);
            do_op(i, 3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, full_lat, 0);
            do_op(i, 3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, full_lat, 0);
            do_op(i, 3'd5, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, zero_lat, 0);
            do_op(i, 3'd7, 32'h1234_5678, 32'h0, 32'h1234_5678, zero_lat, 0);
            do_op(i, 3'd6, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, zero_lat, 0);

            // Flush mid-calculation together with a new request: both are dropped.
            in_valid[i] = 1'b1; op[i] = 3'd5; rs1[i] = 32'd1000; rs2[i] = 32'd3;
            @(negedge clock);
            in_valid[i] = 1'b0;
            repeat (5) @(negedge clock);
            flush[i] = 1'b1; in_valid[i] = 1'b1; op[i] = 3'd0; rs1[i] = 32'd9; rs2[i] = 32'd9;
            @(negedge clock);
            flush[i] = 1'b0; in_valid[i] = 1'b0;
            chk($sformatf("u%0d_flush_ready", i), 64'(in_ready[i]), 64'(1));
            chk($sformatf("u%0d_flush_busy", i), 64'(busy[i]), 64'(0));
            chk($sformatf("u%0d_flush_keep_result", i), 64'(result[i]), 64'(32'hFFFF_FFF9));
            repeat (40) @(negedge clock);
            chk($sformatf("u%0d_flush_no_valid", i), 64'(out_valid[i]), 64'(0));
            do_op(i, 3'd5, 32'd100, 32'd7, 32'd14, full_lat, 0);
        end

        for (int n = 0; n < 80; n++) begin
            int          i;
            logic [2:0]  o;
            logic [31:0] a, b;
            i = n % 2;
            o = 3'($urandom_range(0, 7));
            a = pick($urandom);
            b = pick($urandom);
            do_op(i, o, a, b, ref_result(o, a, b), ref_lat(i, o, a, b), $urandom_range(0, 2));
        end

        // Reset during an operation clears the held result as well.
        in_valid[0] = 1'b1; op[0] = 3'd0; rs1[0] = 32'd12345; rs2[0] = 32'd678;
        @(negedge clock);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("u0_midreset_result", 64'(result[0]), 64'(0));
        chk("u0_midreset_ready", 64'(in_ready[0]), 64'(1));
        do_op(0, 3'd0, 32'd12345, 32'd678, 32'd8369910, 33, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
